// File: rtl/udp_feed_pkg.sv
// rtl/udp_feed_pkg.sv - frame state type, payload constants and header byte helper
package udp_feed_pkg;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    HOLD = 2'd2
  } frame_state_t;

  localparam logic [31:0] DEF_MAGIC       = 32'h4D594445;
  localparam int          DEF_HDR_LEN     = 64;
  localparam int          DEF_DATA_LEN    = 4096;
  localparam int          DEF_PAYLOAD_LEN = DEF_HDR_LEN + DEF_DATA_LEN;
  localparam int          DEF_FIFO_DEPTH  = 2048;

  // Header field byte offsets; everything from OFS_PAD up to the end of the header is zero.
  localparam int OFS_MAGIC = 0;
  localparam int OFS_SEQ   = 4;
  localparam int OFS_DLEN  = 8;
  localparam int OFS_UNDER = 10;
  localparam int OFS_LEVEL = 12;
  localparam int OFS_PAD   = 14;

  // Big-endian header byte at position idx.
  function automatic logic [7:0] hdr_byte(
    input int          idx,
    input logic [31:0] magic,
    input logic [31:0] seq,
    input logic [15:0] dlen,
    input logic [15:0] under,
    input logic [15:0] level
  );
    logic [31:0] sel;
    int          rel;
    sel = 32'h0;
    rel = 0;
    if (idx >= OFS_MAGIC && idx < OFS_SEQ) begin
      sel = magic;
      rel = OFS_SEQ - 1 - idx;
    end else if (idx >= OFS_SEQ && idx < OFS_DLEN) begin
      sel = seq;
      rel = OFS_DLEN - 1 - idx;
    end else if (idx >= OFS_DLEN && idx < OFS_UNDER) begin
      sel = {16'h0, dlen};
      rel = OFS_UNDER - 1 - idx;
    end else if (idx >= OFS_UNDER && idx < OFS_LEVEL) begin
      sel = {16'h0, under};
      rel = OFS_LEVEL - 1 - idx;
    end else if (idx >= OFS_LEVEL && idx < OFS_PAD) begin
      sel = {16'h0, level};
      rel = OFS_PAD - 1 - idx;
    end
    sel = sel >> (8 * rel);
    return sel[7:0];
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// rtl/sync_word_fifo.sv - single-clock word FIFO with registered full, empty and level
module sync_word_fifo #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [LW-1:0]    level_next;

  // full is a register, so a pop in the same cycle does not open a slot for a write.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;
  assign head = mem[rd_ptr];

  // Occupancy after this edge; the flags are registered from it.
  always_comb begin
    level_next = level;
    if (push && !pop)
      level_next = level + LW'(1);
    else if (pop && !push)
      level_next = level - LW'(1);
  end

  // Storage array, no reset needed since empty masks stale contents.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      full  <= (level_next == LW'(DEPTH));
      empty <= (level_next == '0);
    end
  end

endmodule

// File: rtl/udp_payload_feeder.sv
// rtl/udp_payload_feeder.sv - FIFO-backed show-ahead byte source for fixed-size UDP payloads
module udp_payload_feeder
  import udp_feed_pkg::*;
#(
  parameter int          PAYLOAD_LEN = DEF_PAYLOAD_LEN,
  parameter int          HDR_LEN     = DEF_HDR_LEN,
  parameter int          DATA_LEN    = DEF_DATA_LEN,
  parameter int          FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter logic [31:0] MAGIC       = DEF_MAGIC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_wr_data,
  input  logic        i_wr_vld,
  output logic        o_wr_rdy,
  input  logic        i_sync_n,
  input  logic        i_rd,
  output logic [7:0]  o_data,
  output logic [31:0] o_seq,
  output logic [15:0] o_underrun,
  output logic [11:0] o_level
);

  localparam int POS_W = $clog2(PAYLOAD_LEN + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [POS_W-1:0] pos;
  frame_state_t     state;
  logic             sync_prev;
  logic             sync_edge;
  logic [31:0]      word_reg;
  logic             word_loaded;
  logic             word_from_fifo;
  logic [15:0]      snap_under;
  logic [15:0]      snap_level;
  logic [31:0]      fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [LVL_W-1:0] fifo_level;
  logic [1:0]       lane;
  logic [31:0]      cur_word;
  logic             cur_from_fifo;
  logic             consume;
  logic             data_consume;

  sync_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (i_wr_data),
    .wr_en   (i_wr_vld),
    .rd_en   (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign o_wr_rdy  = ~fifo_full;
  assign o_level   = 12'(fifo_level);
  assign sync_edge = sync_prev & ~i_sync_n;
  assign lane      = pos[1:0] - 2'(HDR_LEN);

  // Until the word register is loaded, the current word is taken live from the FIFO head
  // (or zero when empty) so the first byte of every word is available with no latency.
  assign cur_word      = word_loaded ? word_reg : (fifo_empty ? 32'h0 : fifo_head);
  assign cur_from_fifo = word_loaded ? word_from_fifo : ~fifo_empty;

  // A sync edge overrides any read in the same cycle; HOLD swallows reads.
  assign consume      = i_rd & (state != HOLD) & ~sync_edge;
  assign data_consume = consume & (state == DATA);

  // Pop on the last byte of a real word, or drop a partially consumed word on sync.
  always_comb begin
    fifo_pop = 1'b0;
    if (sync_edge)
      fifo_pop = (state == DATA) && word_loaded && word_from_fifo && (lane != 2'd0);
    else
      fifo_pop = data_consume && (lane == 2'd3) && cur_from_fifo;
  end

  // Show-ahead output byte selected from header fields, word register or idle zero.
  always_comb begin
    o_data = 8'h00;
    case (state)
      HDR:
        o_data = hdr_byte(int'(pos), MAGIC, o_seq, 16'(DATA_LEN), snap_under, snap_level);
      DATA:
        case (lane)
          2'd0:    o_data = cur_word[31:24];
          2'd1:    o_data = cur_word[23:16];
          2'd2:    o_data = cur_word[15:8];
          default: o_data = cur_word[7:0];
        endcase
      default:
        o_data = 8'h00;
    endcase
  end

  // Frame position, state machine, sequence number and word register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos            <= '0;
      state          <= HDR;
      o_seq          <= 32'h0;
      sync_prev      <= 1'b1;
      word_reg       <= 32'h0;
      word_loaded    <= 1'b0;
      word_from_fifo <= 1'b0;
    end else begin
      sync_prev <= i_sync_n;
      if (sync_edge) begin
        pos         <= '0;
        state       <= HDR;
        o_seq       <= o_seq + 32'd1;
        word_loaded <= 1'b0;
      end else if (consume) begin
        pos <= pos + POS_W'(1);
        if (state == HDR && pos == POS_W'(HDR_LEN - 1))
          state <= DATA;
        if (state == DATA && pos == POS_W'(PAYLOAD_LEN - 1))
          state <= HOLD;
        if (state == DATA) begin
          if (lane == 2'd3) begin
            word_loaded <= 1'b0;
          end else begin
            word_loaded    <= 1'b1;
            word_reg       <= cur_word;
            word_from_fifo <= cur_from_fifo;
          end
        end
      end else if (state == DATA && !word_loaded) begin
        word_loaded    <= 1'b1;
        word_reg       <= cur_word;
        word_from_fifo <= cur_from_fifo;
      end
    end
  end

  // Header snapshot follows the live counters until byte 0 of the frame is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_under <= 16'h0;
      snap_level <= 16'h0;
    end else if (sync_edge || (state == HDR && pos == '0)) begin
      snap_under <= o_underrun;
      snap_level <= 16'(fifo_level);
    end
  end

  // Saturating count of data bytes served from an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      o_underrun <= 16'h0;
    else if (data_consume && !cur_from_fifo && o_underrun != 16'hFFFF)
      o_underrun <= o_underrun + 16'd1;
  end

endmodule

// File: tb/tb_udp_payload_feeder.sv
// tb/tb_udp_payload_feeder.sv - directed self-checking bench for udp_payload_feeder
module tb_udp_payload_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_wr_data;
  logic        i_wr_vld;
  logic        o_wr_rdy;
  logic        i_sync_n;
  logic        i_rd;
  logic [7:0]  o_data;
  logic [31:0] o_seq;
  logic [15:0] o_underrun;
  logic [11:0] o_level;

  int checks = 0;
  int errors = 0;

  always #4 clk = ~clk;

  udp_payload_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .i_wr_data  (i_wr_data),
    .i_wr_vld   (i_wr_vld),
    .o_wr_rdy   (o_wr_rdy),
    .i_sync_n   (i_sync_n),
    .i_rd       (i_rd),
    .o_data     (o_data),
    .o_seq      (o_seq),
    .o_underrun (o_underrun),
    .o_level    (o_level)
  );

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %h expected %h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int p, input logic [31:0] seq, input logic [15:0] und,
                                          input logic [15:0] lvl, input logic [31:0] base, input bit zero_data);
    logic [31:0] w;
    if (p >= 4160) return 8'h00;
    if (p < 64) begin
      case (p)
        0:  return 8'h4D;
        1:  return 8'h59;
        2:  return 8'h44;
        3:  return 8'h45;
        4:  return seq[31:24];
        5:  return seq[23:16];
        6:  return seq[15:8];
        7:  return seq[7:0];
        8:  return 8'h10;
        9:  return 8'h00;
        10: return und[15:8];
        11: return und[7:0];
        12: return lvl[15:8];
        13: return lvl[7:0];
        default: return 8'h00;
      endcase
    end
    if (zero_data) return 8'h00;
    w = base + 32'((p - 64) / 4);
    case ((p - 64) % 4)
      0:       return w[31:24];
      1:       return w[23:16];
      2:       return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  task automatic write_words(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      i_wr_data = base + 32'(k);
      i_wr_vld  = 1'b1;
      @(posedge clk);
      #1;
    end
    i_wr_vld = 1'b0;
  endtask

  task automatic read_bytes(input int from, input int n, input logic [31:0] seq, input logic [15:0] und,
                            input logic [15:0] lvl, input logic [31:0] base, input bit zero_data, input bit do_chk);
    for (int i = 0; i < n; i++) begin
      if (do_chk)
        chk("byte", from + i, 32'(o_data), 32'(exp_byte(from + i, seq, und, lvl, base, zero_data)));
      i_rd = 1'b1;
      @(posedge clk);
      #1;
    end
    i_rd = 1'b0;
  endtask

  task automatic sync_pulse(input bit with_rd, output logic [7:0] data_after, output logic [31:0] seq_after);
    i_rd     = with_rd;
    i_sync_n = 1'b0;
    @(posedge clk);
    #1;
    i_rd       = 1'b0;
    data_after = o_data;
    seq_after  = o_seq;
    repeat (3) @(posedge clk);
    #1 i_sync_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [31:0] s;
    logic [31:0] base_b;
    logic [31:0] base_d;
    base_b = 32'h11223344;
    base_d = 32'hC0DE0000;

    rst       = 1'b1;
    i_wr_data = 32'h0;
    i_wr_vld  = 1'b0;
    i_sync_n  = 1'b1;
    i_rd      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    chk("rst_data", 0, 32'(o_data), 32'h4D);
    chk("rst_seq", 0, o_seq, 32'h0);
    chk("rst_underrun", 0, 32'(o_underrun), 32'h0);
    chk("rst_level", 0, 32'(o_level), 32'h0);
    chk("rst_wr_rdy", 0, 32'(o_wr_rdy), 32'h1);

    // Full frame from 1024 buffered words
    write_words(1024, 32'h00010203);
    chk("f1_level_pre", 0, 32'(o_level), 32'd1024);
    read_bytes(0, 4160, 32'h0, 16'h0, 16'h0400, 32'h00010203, 1'b0, 1'b1);
    chk("f1_level_post", 0, 32'(o_level), 32'd0);
    chk("f1_underrun", 0, 32'(o_underrun), 32'h0);
    read_bytes(4160, 5, 32'h0, 16'h0, 16'h0, 32'h0, 1'b1, 1'b1);
    chk("hold_underrun", 0, 32'(o_underrun), 32'h0);

    // Empty FIFO frame
    sync_pulse(1'b0, d, s);
    chk("f2_sync_data", 0, 32'(d), 32'h4D);
    chk("f2_sync_seq", 0, s, 32'd1);
    read_bytes(0, 4160, 32'd1, 16'h0, 16'h0, 32'h0, 1'b1, 1'b1);
    chk("f2_underrun", 0, 32'(o_underrun), 32'h1000);
    sync_pulse(1'b0, d, s);
    chk("f3_sync_seq", 0, s, 32'd2);
    read_bytes(0, 14, 32'd2, 16'h1000, 16'h0, 32'h0, 1'b1, 1'b1);

    // Sync mid-header, then sync with a partially consumed word
    write_words(20, base_b);
    sync_pulse(1'b0, d, s);
    chk("f4_sync_data", 0, 32'(d), 32'h4D);
    chk("f4_sync_seq", 0, s, 32'd3);
    read_bytes(0, 102, 32'd3, 16'h1000, 16'd20, base_b, 1'b0, 1'b1);
    chk("f4_level", 0, 32'(o_level), 32'd11);
    chk("f4_underrun", 0, 32'(o_underrun), 32'h1000);
    sync_pulse(1'b1, d, s);
    chk("f5_sync_rd_data", 0, 32'(d), 32'h4D);
    chk("f5_sync_seq", 0, s, 32'd4);
    chk("f5_level", 0, 32'(o_level), 32'd10);
    read_bytes(0, 70, 32'd4, 16'h1000, 16'd10, base_b + 32'd10, 1'b0, 1'b1);
    chk("f5_level_70", 0, 32'(o_level), 32'd9);
    sync_pulse(1'b1, d, s);
    chk("f6_sync_rd_data", 0, 32'(d), 32'h4D);
    chk("f6_sync_seq", 0, s, 32'd5);
    chk("f6_level", 0, 32'(o_level), 32'd8);
    chk("f6_underrun", 0, 32'(o_underrun), 32'h1000);

    // Asynchronous reset mid-frame
    write_words(776, 32'h5A000000);
    chk("f6_level_fill", 0, 32'(o_level), 32'd784);
    read_bytes(0, 2000, 32'd5, 16'h0, 16'h0, 32'h0, 1'b0, 1'b0);
    chk("f6_level_2000", 0, 32'(o_level), 32'd300);
    rst = 1'b1;
    #1;
    chk("arst_level", 0, 32'(o_level), 32'd0);
    chk("arst_seq", 0, o_seq, 32'h0);
    chk("arst_data", 0, 32'(o_data), 32'h4D);
    chk("arst_wr_rdy", 0, 32'(o_wr_rdy), 32'h1);
    chk("arst_underrun", 0, 32'(o_underrun), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill to full, overflow writes, write during pop while full
    write_words(2048, base_d);
    chk("full_wr_rdy", 0, 32'(o_wr_rdy), 32'h0);
    chk("full_level", 0, 32'(o_level), 32'd2048);
    write_words(5, 32'hEEEE0000);
    chk("ovf_level", 0, 32'(o_level), 32'd2048);
    chk("ovf_wr_rdy", 0, 32'(o_wr_rdy), 32'h0);
    read_bytes(0, 67, 32'h0, 16'h0, 16'h0800, base_d, 1'b0, 1'b1);
    chk("byte", 67, 32'(o_data), 32'(exp_byte(67, 32'h0, 16'h0, 16'h0800, base_d, 1'b0)));
    i_rd      = 1'b1;
    i_wr_vld  = 1'b1;
    i_wr_data = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    i_rd     = 1'b0;
    i_wr_vld = 1'b0;
    chk("popwr_level", 0, 32'(o_level), 32'd2047);
    chk("popwr_wr_rdy", 0, 32'(o_wr_rdy), 32'h1);
    read_bytes(68, 4092, 32'h0, 16'h0, 16'h0800, base_d, 1'b0, 1'b1);
    chk("f7_level", 0, 32'(o_level), 32'd1024);
    sync_pulse(1'b0, d, s);
    chk("f8_sync_seq", 0, s, 32'd1);
    read_bytes(0, 4160, 32'd1, 16'h0, 16'h0400, base_d + 32'd1024, 1'b0, 1'b1);
    chk("f8_level", 0, 32'(o_level), 32'd0);
    chk("f8_underrun", 0, 32'(o_underrun), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
